// File: rtl/pipe_fwd_tracker_if.sv
// Decode-side bundle of the forwarding tracker: decode instruction fields,
// register-file operands in, forwarding selects/data and the decode stall out.
interface pipe_fwd_tracker_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 2
);
  logic              id_valid;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wr_addr;
  logic [SEL_W-1:0]  id_rdy_stage;
  logic [REG_AW-1:0] id_src_a;
  logic [REG_AW-1:0] id_src_b;
  logic              id_use_a;
  logic              id_use_b;
  logic [DATA_W-1:0] rf_data_a;
  logic [DATA_W-1:0] rf_data_b;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic [DATA_W-1:0] fwd_data_a;
  logic [DATA_W-1:0] fwd_data_b;
  logic              id_stall;

  modport master (
    output id_valid, id_wr_en, id_wr_addr, id_rdy_stage,
           id_src_a, id_src_b, id_use_a, id_use_b, rf_data_a, rf_data_b,
    input  fwd_sel_a, fwd_sel_b, fwd_data_a, fwd_data_b, id_stall
  );

  modport slave (
    input  id_valid, id_wr_en, id_wr_addr, id_rdy_stage,
           id_src_a, id_src_b, id_use_a, id_use_b, rf_data_a, rf_data_b,
    output fwd_sel_a, fwd_sel_b, fwd_data_a, fwd_data_b, id_stall
  );
endinterface

// File: rtl/pipe_fwd_tracker.sv
// Per-stage destination tracker for the in-order pipeline: forwarding selects
// and data for two decode operands, load-use interlock and a stall counter.
module pipe_fwd_tracker #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  pipe_fwd_tracker_if.slave        id_bus,
  input  logic [STAGES*DATA_W-1:0] stage_res,
  input  logic                     hold,
  input  logic                     flush_id,
  input  logic                     flush_all,
  output logic [31:0]              stall_cnt
);

  typedef struct packed {
    logic              v;
    logic              we;
    logic [REG_AW-1:0] wa;
    logic [SEL_W-1:0]  rdy;
  } entry_t;

  typedef entry_t [STAGES-1:0] ent_arr_t;

  typedef struct packed {
    logic              unready;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } match_t;

  // ent[i] tracks pipeline stage i+1
  ent_arr_t ent;
  entry_t   fresh;
  match_t   ma;
  match_t   mb;
  logic     stall;
  logic     capture;

  // Ascending scan with a hit flag so the youngest producer wins.
  function automatic match_t lookup(
    input logic [REG_AW-1:0]        src,
    input logic                     rd,
    input ent_arr_t                 e,
    input logic [STAGES*DATA_W-1:0] res,
    input logic [DATA_W-1:0]        rf
  );
    match_t m;
    logic   hit;
    m.unready = 1'b0;
    m.sel     = '0;
    m.data    = rf;
    hit       = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (!hit && rd && (src != '0) && e[i].v && e[i].we &&
          (e[i].wa != '0) && (e[i].wa == src)) begin
        hit       = 1'b1;
        m.sel     = SEL_W'(i + 1);
        m.data    = res[i*DATA_W +: DATA_W];
        m.unready = (SEL_W'(i + 1) < e[i].rdy);
      end
    end
    return m;
  endfunction

  always_comb begin
    ma = lookup(id_bus.id_src_a, id_bus.id_use_a, ent, stage_res, id_bus.rf_data_a);
    mb = lookup(id_bus.id_src_b, id_bus.id_use_b, ent, stage_res, id_bus.rf_data_b);
    stall = id_bus.id_valid & (ma.unready | mb.unready);

    id_bus.fwd_sel_a  = ma.sel;
    id_bus.fwd_data_a = ma.data;
    id_bus.fwd_sel_b  = mb.sel;
    id_bus.fwd_data_b = mb.data;
    id_bus.id_stall   = stall;
  end

  always_comb begin
    capture   = id_bus.id_valid & ~stall & ~flush_id;
    fresh.v   = 1'b1;
    fresh.we  = id_bus.id_wr_en;
    fresh.wa  = id_bus.id_wr_addr;
    // A ready stage of 0 is the same as an ALU result ready in stage 1.
    fresh.rdy = (id_bus.id_rdy_stage == '0) ? SEL_W'(1) : id_bus.id_rdy_stage;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent <= '0;
    end else if (flush_all) begin
      for (int unsigned i = 0; i < STAGES; i++) ent[i].v <= 1'b0;
    end else if (!hold) begin
      for (int unsigned i = 1; i < STAGES; i++) ent[i] <= ent[i-1];
      ent[0] <= capture ? fresh : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
